// File: rtl/dsp_addsub_simd_if.sv
// Streaming handshake and data bus for the SIMD add/subtract block.
// The block sits on the slave side; the source/sink of beats uses the master side.
interface dsp_addsub_simd_if #(
    parameter int unsigned width = 12,
    parameter int unsigned lanes = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     op;
    logic [lanes*width-1:0]   a;
    logic [lanes*width-1:0]   b;
    logic                     out_valid;
    logic                     out_ready;
    logic [lanes*width-1:0]   y;
    logic [lanes-1:0]         ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/dsp_addsub_simd.sv
// SIMD add/subtract over independent lanes with a globally stalled valid/ready pipeline.
// Define DSP_ADDSUB_SAT_EN to saturate overflowing lanes instead of wrapping.
module dsp_addsub_simd #(
    parameter int unsigned width   = 12,
    parameter int unsigned lanes   = 4,
    parameter int unsigned latency = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    dsp_addsub_simd_if.slave     bus
);

    localparam int unsigned data_w = lanes * width;

    // Reject configurations that cannot map onto one 48-bit ALU
    if (lanes < 1 || lanes > 4 || width < 2 || data_w > 48) begin : g_bad_lanes
        $error("dsp_addsub_simd: lanes*width must be <= 48 with 1..4 lanes");
    end
    if (latency < 1 || latency > 3) begin : g_bad_latency
        $error("dsp_addsub_simd: latency must be 1..3");
    end

    logic              advance;
    logic [data_w-1:0] calc_a;
    logic [data_w-1:0] calc_b;
    logic              calc_op;
    logic              calc_valid;
    logic [data_w-1:0] y_next;
    logic [lanes-1:0]  ovf_next;

    // Global enable: the whole pipe moves whenever the output slot is free or draining
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    if (latency == 1) begin : g_direct
        // Single stage: the ALU feeds the output register straight from the ports
        assign calc_a     = bus.a;
        assign calc_b     = bus.b;
        assign calc_op    = bus.op;
        assign calc_valid = bus.in_valid;
    end else begin : g_pipe
        localparam int unsigned depth = latency - 1;

        logic [data_w-1:0] a_q   [depth];
        logic [data_w-1:0] b_q   [depth];
        logic [depth-1:0]  op_q;
        logic [depth-1:0]  vld_q;

        // Operand stages carry no reset; only the valid bits need a known state
        always_ff @(posedge clock) begin
            if (advance) begin
                a_q[0]  <= bus.a;
                b_q[0]  <= bus.b;
                op_q[0] <= bus.op;
                for (int s = 1; s < int'(depth); s++) begin
                    a_q[s]  <= a_q[s-1];
                    b_q[s]  <= b_q[s-1];
                    op_q[s] <= op_q[s-1];
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q[0] <= bus.in_valid;
                for (int s = 1; s < int'(depth); s++) begin
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        assign calc_a     = a_q[depth-1];
        assign calc_b     = b_q[depth-1];
        assign calc_op    = op_q[depth-1];
        assign calc_valid = vld_q[depth-1];
    end

    // Per-lane ALU on width+1 bits: the extra bit holds the exact sign, so overflow is
    // simply a disagreement between the two top bits, including a - most_negative.
    always_comb begin : lane_alu
        logic [width:0] ext_a;
        logic [width:0] ext_b;
        logic [width:0] sum;
        y_next   = '0;
        ovf_next = '0;
        ext_a    = '0;
        ext_b    = '0;
        sum      = '0;
        for (int i = 0; i < int'(lanes); i++) begin
            ext_a = {calc_a[i*width + width - 1], calc_a[i*width +: width]};
            ext_b = {calc_b[i*width + width - 1], calc_b[i*width +: width]}
                    ^ {(width + 1){calc_op}};
            sum   = ext_a + ext_b + (width + 1)'(calc_op);
            ovf_next[i] = sum[width] ^ sum[width-1];
`ifdef DSP_ADDSUB_SAT_EN
            if (ovf_next[i]) begin
                y_next[i*width +: width] = sum[width] ? {1'b1, {(width - 1){1'b0}}}
                                                      : {1'b0, {(width - 1){1'b1}}};
            end else begin
                y_next[i*width +: width] = sum[width-1:0];
            end
`else
            y_next[i*width +: width] = sum[width-1:0];
`endif
        end
    end

    // Output stage holds while a valid beat waits on a stalled sink
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.ovf       <= '0;
        end else if (advance) begin
            bus.out_valid <= calc_valid;
            bus.y         <= y_next;
            bus.ovf       <= ovf_next;
        end
    end

endmodule

// File: tb/tb_dsp_addsub_simd.sv
// Directed checks for dsp_addsub_simd: 4x12 lanes at latency 2, and 1x32 at latency 1.
module tb_dsp_addsub_simd;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dsp_addsub_simd_if #(.width(12), .lanes(4)) bus0 ();
    dsp_addsub_simd_if #(.width(32), .lanes(1)) bus1 ();

    dsp_addsub_simd #(.width(12), .lanes(4), .latency(2)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    dsp_addsub_simd #(.width(32), .lanes(1), .latency(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic        op;
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] y_wrap;
        logic [47:0] y_sat;
        logic [3:0]  ovf;
    } vec_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y_wrap;
        logic [31:0] y_sat;
        logic        ovf;
    } vec32_t;

    vec_t   vecs   [8];
    vec32_t vecs32 [3];
    int     n_vec;
    int     n_err;
    int     q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] ey(input int i);
`ifdef DSP_ADDSUB_SAT_EN
        return vecs[i].y_sat;
`else
        return vecs[i].y_wrap;
`endif
    endfunction

    function automatic logic [31:0] ey32(input int i);
`ifdef DSP_ADDSUB_SAT_EN
        return vecs32[i].y_sat;
`else
        return vecs32[i].y_wrap;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input int i);
        bus0.in_valid = 1'b1;
        bus0.op       = vecs[i].op;
        bus0.a        = vecs[i].a;
        bus0.b        = vecs[i].b;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int nxt;
        logic [47:0] y_hold;

        // Lanes listed lane3..lane0, 12 bits each
        vecs[0] = '{1'b0, 48'hFFF_005_064_7FF, 48'h010_003_01C_001,
                    48'h00F_008_080_800, 48'h00F_008_080_7FF, 4'b0001};
        vecs[1] = '{1'b1, 48'h00A_800_007_000, 48'hFFB_001_007_001,
                    48'h00F_7FF_000_FFF, 48'h00F_800_000_FFF, 4'b0100};
        vecs[2] = '{1'b1, 48'h7FF_800_FFF_000, 48'hFFF_800_800_800,
                    48'h800_000_7FF_800, 48'h7FF_000_7FF_7FF, 4'b1001};
        vecs[3] = '{1'b0, 48'hFFF_FFF_FFF_FFF, 48'h001_001_001_001,
                    48'h000_000_000_000, 48'h000_000_000_000, 4'b0000};
        vecs[4] = '{1'b0, 48'h800_800_400_000, 48'h800_FFF_400_000,
                    48'h000_7FF_800_000, 48'h800_800_7FF_000, 4'b1110};
        vecs[5] = '{1'b1, 48'h123_456_789_ABC, 48'h023_056_089_0BC,
                    48'h100_400_700_A00, 48'h100_400_700_A00, 4'b0000};
        vecs[6] = '{1'b0, 48'h7FF_000_555_AAA, 48'h000_7FF_AAA_555,
                    48'h7FF_7FF_FFF_FFF, 48'h7FF_7FF_FFF_FFF, 4'b0000};
        vecs[7] = '{1'b1, 48'h000_001_800_7FF, 48'h7FF_002_7FF_800,
                    48'h801_FFF_001_FFF, 48'h801_FFF_800_7FF, 4'b0011};

        vecs32[0] = '{1'b0, 32'd1, 32'hFFFF_0001, 32'hFFFF_0002, 32'hFFFF_0002, 1'b0};
        vecs32[1] = '{1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs32[2] = '{1'b1, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};

        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus0.in_valid = 1'b0; bus0.op = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.op = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", 64'(bus0.out_valid), 64'(1'b0));
        chk("rst_y",         64'(bus0.y),         64'(48'h0));
        chk("rst_ovf",       64'(bus0.ovf),       64'(4'h0));
        chk("rst_out_valid32", 64'(bus1.out_valid), 64'(1'b0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1 chk("rst_in_ready", 64'(bus0.in_ready), 64'(1'b1));

        // Streaming: 8 back-to-back beats, results on consecutive cycles at latency 2
        step();
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) drive0(c);
            else       bus0.in_valid = 1'b0;
            #1 chk("stream_in_ready", 64'(bus0.in_ready), 64'(1'b1));
            step();
            if (c == 0) begin
                chk("stream_latency_gap", 64'(bus0.out_valid), 64'(1'b0));
            end else begin
                chk("stream_out_valid", 64'(bus0.out_valid), 64'(1'b1));
                chk("stream_y",   64'(bus0.y),   64'(ey(c - 1)));
                chk("stream_ovf", 64'(bus0.ovf), 64'(vecs[c-1].ovf));
            end
        end
        step();
        chk("stream_drained", 64'(bus0.out_valid), 64'(1'b0));

        // Backpressure: sink stalls cycles 3..6 with a full pipe, bubble at cycle 10
        nxt = 0;
        y_hold = '0;
        for (int t = 0; t < 24; t++) begin
            if (nxt < 8 && t != 10) drive0(nxt);
            else                    bus0.in_valid = 1'b0;
            bus0.out_ready = !(t >= 3 && t <= 6);
            #1;
            if (t >= 3 && t <= 6) begin
                chk("bp_in_ready_stall", 64'(bus0.in_ready),  64'(1'b0));
                chk("bp_out_valid_hold", 64'(bus0.out_valid), 64'(1'b1));
                if (t == 3) y_hold = bus0.y;
                else chk("bp_y_stable", 64'(bus0.y), 64'(y_hold));
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (q.size() == 0) begin
                    chk("bp_unexpected_beat", 64'(1'b1), 64'(1'b0));
                end else begin
                    chk("bp_y",   64'(bus0.y),   64'(ey(q[0])));
                    chk("bp_ovf", 64'(bus0.ovf), 64'(vecs[q[0]].ovf));
                    void'(q.pop_front());
                end
            end
            if (bus0.in_valid && bus0.in_ready) begin
                q.push_back(nxt);
                nxt++;
            end
            step();
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        chk("bp_all_accepted", 64'(nxt), 64'(8));
        chk("bp_all_emitted",  64'(q.size()), 64'(0));

        // Reset with beats in flight: clears immediately, nothing emerges afterwards
        step();
        drive0(0);
        step();
        drive0(1);
        step();
        bus0.in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus0.out_valid), 64'(1'b0));
        chk("midrst_y",         64'(bus0.y),         64'(48'h0));
        chk("midrst_ovf",       64'(bus0.ovf),       64'(4'h0));
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("midrst_no_emit", 64'(bus0.out_valid), 64'(1'b0));
        end

        // Single 32-bit lane at latency 1
        for (int i = 0; i < 3; i++) begin
            bus1.in_valid = 1'b1;
            bus1.op = vecs32[i].op;
            bus1.a  = vecs32[i].a;
            bus1.b  = vecs32[i].b;
            step();
            chk("w32_out_valid", 64'(bus1.out_valid), 64'(1'b1));
            chk("w32_y",   64'(bus1.y),   64'(ey32(i)));
            chk("w32_ovf", 64'(bus1.ovf), 64'(vecs32[i].ovf));
        end
        bus1.in_valid = 1'b0;
        step();
        chk("w32_bubble", 64'(bus1.out_valid), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
